// File: rtl/keypad_pkg.sv
// Shared keypad/display constants: key codes, default timing, FSM state types.
package keypad_pkg;

    localparam int SCAN_DIV_DEFAULT       = 4000;
    localparam int DEBOUNCE_SCANS_DEFAULT = 4;

    localparam logic [3:0] KEY_A    = 4'd10;
    localparam logic [3:0] KEY_B    = 4'd11;
    localparam logic [3:0] KEY_C    = 4'd12;
    localparam logic [3:0] KEY_D    = 4'd13;
    localparam logic [3:0] KEY_STAR = 4'd14;
    localparam logic [3:0] KEY_HASH = 4'd15;
    localparam logic [4:0] KEY_NONE = 5'h10;

    typedef enum logic [1:0] {
        DB_RELEASED,
        DB_PRESS_WAIT,
        DB_HELD,
        DB_RELEASE_WAIT
    } db_state_e;

    typedef enum logic {
        ENT_IDLE,
        ENT_CONVERT
    } entry_state_e;

    // Matrix index (row*4+col) to key code.
    function automatic logic [3:0] key_code_of(input logic [3:0] idx);
        logic [3:0] code;
        case (idx)
            4'd0:    code = 4'd1;
            4'd1:    code = 4'd2;
            4'd2:    code = 4'd3;
            4'd3:    code = KEY_A;
            4'd4:    code = 4'd4;
            4'd5:    code = 4'd5;
            4'd6:    code = 4'd6;
            4'd7:    code = KEY_B;
            4'd8:    code = 4'd7;
            4'd9:    code = 4'd8;
            4'd10:   code = 4'd9;
            4'd11:   code = KEY_C;
            4'd12:   code = KEY_STAR;
            4'd13:   code = 4'd0;
            4'd14:   code = KEY_HASH;
            default: code = KEY_D;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/keypad_entry_scanner.sv
// Row scanner, column synchronizer and per-scan debounce FSM for a 4x4 keypad.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    output logic [3:0] row,
    input  logic [3:0] col,
    output logic       key_valid,
    output logic [3:0] key_code
);
    localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_SCANS - 1);

    logic [3:0]       col_meta_q, col_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [1:0]       row_idx_q, row_idx_d;
    logic [3:0]       row_q, row_d;
    logic [11:0]      scan_q, scan_d;
    db_state_e        db_state_q, db_state_d;
    logic [3:0]       db_key_q, db_key_d;
    logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
    logic             key_valid_q, key_valid_d;
    logic [3:0]       key_code_q, key_code_d;

    logic        tick, scan_end, cand_valid;
    logic [3:0]  cand_idx;
    logic [15:0] pressed_bits;

    assign tick     = (div_q == DIV_LAST);
    assign scan_end = tick && (row_idx_q == 2'd3);
    // Row 3 is being sampled right now, so it comes straight from the synchronizer.
    assign pressed_bits = {~col_sync_q, scan_q};

    always_comb begin
        cand_valid = 1'b0;
        cand_idx   = 4'd0;
        for (int i = 15; i >= 0; i--) begin
            if (pressed_bits[i]) begin
                cand_valid = 1'b1;
                cand_idx   = 4'(i);
            end
        end
    end

    always_comb begin
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        row_idx_d = tick ? row_idx_q + 2'd1 : row_idx_q;
        row_d     = ~(4'b0001 << row_idx_d);
        scan_d    = scan_q;
        if (tick) begin
            case (row_idx_q)
                2'd0:    scan_d[3:0]  = ~col_sync_q;
                2'd1:    scan_d[7:4]  = ~col_sync_q;
                2'd2:    scan_d[11:8] = ~col_sync_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        db_state_d  = db_state_q;
        db_key_d    = db_key_q;
        db_cnt_d    = db_cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        if (scan_end) begin
            case (db_state_q)
                DB_RELEASED: begin
                    if (cand_valid) begin
                        db_state_d = DB_PRESS_WAIT;
                        db_key_d   = cand_idx;
                        db_cnt_d   = CNT_W'(1);
                    end
                end
                DB_PRESS_WAIT: begin
                    if (!cand_valid) begin
                        db_state_d = DB_RELEASED;
                    end else if (cand_idx != db_key_q) begin
                        db_key_d = cand_idx;
                        db_cnt_d = CNT_W'(1);
                    end else if (db_cnt_q >= DB_LAST) begin
                        db_state_d  = DB_HELD;
                        key_valid_d = 1'b1;
                        key_code_d  = key_code_of(db_key_q);
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_W'(1);
                    end
                end
                DB_HELD: begin
                    if (!cand_valid) begin
                        db_state_d = DB_RELEASE_WAIT;
                        db_cnt_d   = CNT_W'(1);
                    end
                end
                default: begin
                    if (cand_valid) begin
                        db_state_d = DB_HELD;
                    end else if (db_cnt_q >= DB_LAST) begin
                        db_state_d = DB_RELEASED;
                    end else begin
                        db_cnt_d = db_cnt_q + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_meta_q  <= 4'hF;
            col_sync_q  <= 4'hF;
            div_q       <= '0;
            row_idx_q   <= 2'd0;
            row_q       <= 4'b1110;
            scan_q      <= '0;
            db_state_q  <= DB_RELEASED;
            db_key_q    <= 4'd0;
            db_cnt_q    <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            col_meta_q  <= col;
            col_sync_q  <= col_meta_q;
            div_q       <= div_d;
            row_idx_q   <= row_idx_d;
            row_q       <= row_d;
            scan_q      <= scan_d;
            db_state_q  <= db_state_d;
            db_key_q    <= db_key_d;
            db_cnt_q    <= db_cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign row       = row_q;
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad decimal entry: 4-digit BCD buffer with edit keys and BCD-to-binary conversion on '#'.
import keypad_pkg::*;

module keypad_entry #(
    parameter int SCAN_DIV       = SCAN_DIV_DEFAULT,
    parameter int DEBOUNCE_SCANS = DEBOUNCE_SCANS_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    output logic [3:0]  row,
    input  logic [3:0]  col,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic [15:0] entry_digits,
    output logic [2:0]  digit_count,
    output logic [15:0] entry_value,
    output logic        entry_done
);
    logic       kv;
    logic [3:0] code;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .row       (row),
        .col       (col),
        .key_valid (kv),
        .key_code  (code)
    );

    entry_state_e state_q, state_d;
    logic [15:0]  digits_q, digits_d;
    logic [2:0]   count_q, count_d;
    logic [15:0]  acc_q, acc_d;
    logic [1:0]   conv_cnt_q, conv_cnt_d;
    logic [15:0]  value_q, value_d;
    logic         done_q, done_d;
    logic [3:0]   nibble;
    logic [15:0]  acc_next;

    // Most significant digit first, so acc*10+digit yields the binary value.
    always_comb begin
        case (conv_cnt_q)
            2'd0:    nibble = digits_q[15:12];
            2'd1:    nibble = digits_q[11:8];
            2'd2:    nibble = digits_q[7:4];
            default: nibble = digits_q[3:0];
        endcase
        acc_next = {acc_q[12:0], 3'b000} + {acc_q[14:0], 1'b0} + {12'd0, nibble};
    end

    always_comb begin
        state_d    = state_q;
        digits_d   = digits_q;
        count_d    = count_q;
        acc_d      = acc_q;
        conv_cnt_d = conv_cnt_q;
        value_d    = value_q;
        done_d     = 1'b0;
        case (state_q)
            ENT_IDLE: begin
                if (kv) begin
                    if (code <= 4'd9) begin
                        if (count_q < 3'd4) begin
                            digits_d = {digits_q[11:0], code};
                            count_d  = count_q + 3'd1;
                        end
                    end else begin
                        case (code)
                            KEY_A: begin
                                if (count_q != 3'd0) begin
                                    digits_d = digits_q >> 4;
                                    count_d  = count_q - 3'd1;
                                end
                            end
                            KEY_STAR: begin
                                digits_d = '0;
                                count_d  = 3'd0;
                            end
                            KEY_HASH: begin
                                if (count_q != 3'd0) begin
                                    state_d    = ENT_CONVERT;
                                    acc_d      = '0;
                                    conv_cnt_d = 2'd0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            default: begin
                if (conv_cnt_q == 2'd3) begin
                    state_d  = ENT_IDLE;
                    value_d  = acc_next;
                    done_d   = 1'b1;
                    digits_d = '0;
                    count_d  = 3'd0;
                end else begin
                    acc_d      = acc_next;
                    conv_cnt_d = conv_cnt_q + 2'd1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ENT_IDLE;
            digits_q   <= '0;
            count_q    <= 3'd0;
            acc_q      <= '0;
            conv_cnt_q <= 2'd0;
            value_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            digits_q   <= digits_d;
            count_q    <= count_d;
            acc_q      <= acc_d;
            conv_cnt_q <= conv_cnt_d;
            value_q    <= value_d;
            done_q     <= done_d;
        end
    end

    assign key_valid    = kv;
    assign key_code     = code;
    assign entry_digits = digits_q;
    assign digit_count  = count_q;
    assign entry_value  = value_q;
    assign entry_done   = done_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Bench for keypad_entry: a keypad model on row/col, an entry-buffer model checked every cycle.
module tb_keypad_entry;

    localparam int SCAN_DIV = 8;
    localparam int DEB      = 2;
    localparam int SCAN_CYC = SCAN_DIV * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  row, col;
    logic        key_valid, entry_done;
    logic [3:0]  key_code;
    logic [15:0] entry_digits, entry_value;
    logic [2:0]  digit_count;
    logic [15:0] pressed = 16'h0000;

    keypad_entry #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
        .clk          (clk),
        .reset        (reset),
        .row          (row),
        .col          (col),
        .key_valid    (key_valid),
        .key_code     (key_code),
        .entry_digits (entry_digits),
        .digit_count  (digit_count),
        .entry_value  (entry_value),
        .entry_done   (entry_done)
    );

    // clock / reset
    always #5 clk = ~clk;

    // Pressed switch shorts its column to its row while that row is driven low.
    always_comb begin
        col = 4'hF;
        for (int r = 0; r < 4; r++) begin
            if (!row[r]) col = col & ~pressed[r*4 +: 4];
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [3:0]  exp_q[$];
    int          digs[$];
    logic [15:0] model_value = 16'd0;
    logic [15:0] pend_value  = 16'd0;
    logic [3:0]  last_code   = 4'd0;
    logic        exp_done    = 1'b0;
    int          pend = 0;
    int          cd   = 0;
    int          ncyc = 0;

    function automatic logic [15:0] model_digits();
        logic [15:0] e = 16'd0;
        foreach (digs[i]) e = e * 16 + 16'(digs[i]);
        return e;
    endfunction

    function automatic logic [15:0] model_number();
        logic [15:0] v = 16'd0;
        foreach (digs[i]) v = v * 10 + 16'(digs[i]);
        return v;
    endfunction

    always @(negedge clk) begin
        logic [3:0] exp_row;
        logic [3:0] code;
        if (reset) begin
            ncyc = 0;
            digs.delete();
            exp_q.delete();
            pend = 0;
            exp_done = 1'b0;
            model_value = 16'd0;
            last_code = 4'd0;
        end else begin
            ncyc++;
            exp_row = ~(4'b0001 << ((ncyc / SCAN_DIV) % 4));
            check("row", row, exp_row);
            check("entry_done", entry_done, exp_done);
            check("entry_value", entry_value, model_value);
            if (pend == 0) begin
                check("entry_digits", entry_digits, model_digits());
                check("digit_count", digit_count, digs.size());
            end
            exp_done = 1'b0;
            if (pend != 0) begin
                cd--;
                if (cd == 0) begin
                    exp_done = 1'b1;
                    model_value = pend_value;
                    digs.delete();
                    pend = 0;
                end
            end
            if (key_valid) begin
                check("key_valid_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    code = exp_q.pop_front();
                    check("key_code_event", key_code, code);
                    last_code = code;
                    if (pend == 0) begin
                        if (code <= 4'd9) begin
                            if (digs.size() < 4) digs.push_back(int'(code));
                        end else if (code == 4'd10) begin
                            if (digs.size() > 0) void'(digs.pop_back());
                        end else if (code == 4'd14) begin
                            digs.delete();
                        end else if (code == 4'd15 && digs.size() > 0) begin
                            // Result becomes visible five cycles after the '#' event.
                            pend = 1;
                            cd = 4;
                            pend_value = model_number();
                        end
                    end
                end
            end else begin
                check("key_code_hold", key_code, last_code);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_scans(input int s);
        repeat (s * SCAN_CYC) @(posedge clk);
    endtask

    task automatic press_key(input int idx, input logic [3:0] code, input int hold);
        exp_q.push_back(code);
        pressed[idx] = 1'b1;
        wait_scans(hold);
        pressed[idx] = 1'b0;
        wait_scans(4);
        check("event_delivered", exp_q.size(), 0);
        exp_q.delete();
    endtask

    // matrix indices (row*4+col)
    localparam int K1 = 0, K2 = 1, K3 = 2, KA = 3, K4 = 4, K5 = 5, K6 = 6;
    localparam int K7 = 8, K8 = 9, K9 = 10, KSTAR = 12, K0 = 13, KHASH = 14;

    initial begin
        int found;
        repeat (3) @(negedge clk);
        check("rst_row", row, 4'b1110);
        check("rst_key_valid", key_valid, 0);
        check("rst_key_code", key_code, 0);
        check("rst_digits", entry_digits, 0);
        check("rst_count", digit_count, 0);
        check("rst_value", entry_value, 0);
        check("rst_done", entry_done, 0);
        #1 reset = 1'b0;

        // held '5' gives a single event
        press_key(K5, 4'd5, 6);
        @(negedge clk);
        check("t1_digits", entry_digits, 16'h0005);
        check("t1_count", digit_count, 1);
        check("t1_code", key_code, 4'd5);

        // 1,2,3,4 then an ignored fifth digit, then '#'
        press_key(KSTAR, 4'd14, 4);
        press_key(K1, 4'd1, 4);
        press_key(K2, 4'd2, 4);
        press_key(K3, 4'd3, 4);
        press_key(K4, 4'd4, 4);
        @(negedge clk);
        check("t2_full", entry_digits, 16'h1234);
        press_key(K7, 4'd7, 4);
        @(negedge clk);
        check("t2_ignored", entry_digits, 16'h1234);
        press_key(KHASH, 4'd15, 4);
        @(negedge clk);
        check("t2_value", entry_value, 16'h04D2);
        check("t2_digits", entry_digits, 16'h0000);
        check("t2_count", digit_count, 0);

        // backspace removes the last digit
        press_key(K9, 4'd9, 4);
        press_key(K0, 4'd0, 4);
        press_key(KA, 4'd10, 4);
        press_key(K5, 4'd5, 4);
        @(negedge clk);
        check("t3_digits", entry_digits, 16'h0095);
        press_key(KHASH, 4'd15, 4);
        @(negedge clk);
        check("t3_value", entry_value, 16'd95);

        // one-scan bounce on '8', then clear and '#' on an empty buffer
        pressed[K8] = 1'b1;
        repeat (SCAN_CYC) @(posedge clk);
        pressed[K8] = 1'b0;
        wait_scans(4);
        press_key(KSTAR, 4'd14, 4);
        press_key(KHASH, 4'd15, 4);
        @(negedge clk);
        check("t4_count", digit_count, 0);
        check("t4_value_kept", entry_value, 16'd95);

        // '3' and '6' together: lowest index wins, partial release gives nothing
        exp_q.push_back(4'd3);
        pressed[K3] = 1'b1;
        pressed[K6] = 1'b1;
        wait_scans(4);
        pressed[K3] = 1'b0;
        wait_scans(4);
        check("t5_event", exp_q.size(), 0);
        pressed[K6] = 1'b0;
        wait_scans(4);
        @(negedge clk);
        check("t5_code", key_code, 4'd3);
        check("t5_digits", entry_digits, 16'h0003);

        // reset in the middle of a conversion
        press_key(K4, 4'd4, 4);
        exp_q.push_back(4'd15);
        pressed[KHASH] = 1'b1;
        found = 0;
        for (int i = 0; i < 8 * SCAN_CYC && found == 0; i++) begin
            @(negedge clk);
            if (key_valid) found = 1;
        end
        check("t6_hash_seen", found, 1);
        @(posedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        pressed = 16'h0000;
        #1;
        check("t6_row", row, 4'b1110);
        check("t6_key_valid", key_valid, 0);
        check("t6_key_code", key_code, 0);
        check("t6_digits", entry_digits, 0);
        check("t6_count", digit_count, 0);
        check("t6_value", entry_value, 0);
        check("t6_done", entry_done, 0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("t6_value_after", entry_value, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        n_checks++;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- 4x4 matrix keypad scanner with debounce and decimal entry buffer; input-side counterpart to the 4-digit multiplexed display driver.
- Drives keypad rows active-low, samples columns, and emits debounced key events.
- Assembles up to 4 decimal digits and converts them sequentially to a 16-bit binary value for the display data input.

Parameters:
- SCAN_DIV, 4000: clk cycles per row-scan tick.
- DEBOUNCE_SCANS, 4: consecutive full scans (4 ticks each) a key state must be stable before it is accepted.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- row  out  4  keypad row drive, active-low, one row low at a time.
- col  in  4  keypad column sense, active-low (pull-ups), asynchronous to clk.
- key_valid  out  1  one-cycle pulse per accepted key press.
- key_code  out  4  code of the last accepted key.
- entry_digits  out  16  BCD entry buffer, digit3..digit0, for live echo.
- digit_count  out  3  number of digits in the buffer, 0..4.
- entry_value  out  16  binary value of the last completed entry.
- entry_done  out  1  one-cycle pulse when entry_value updates.

Behaviour:
- Reset values: row=4'b1110, key_valid=0, key_code=0, entry_digits=0, digit_count=0, entry_value=0, entry_done=0, FSMs in IDLE. Reset is asynchronous, so reset mid-conversion aborts the conversion with no entry_done.
- col passes through a 2-flop synchronizer.
- Tick counter wraps at SCAN_DIV-1; tick=1 on the wrap cycle.
- On each tick, the synchronized col for the currently driven row is captured, then row_idx increments mod 4 and row=~(1<<row_idx).
- A full scan is 4 ticks (rows 0..3). At scan end the candidate is the lowest-index pressed key (index=row*4+col, col0 = LSB), or NONE.
- Key map:
  - row0: 1,2,3,A
  - row1: 4,5,6,B
  - row2: 7,8,9,C
  - row3: *,0,#,D
- Codes: digits 0-9 map to 0-9; A=10, B=11, C=12, D=13, *=14, #=15.
- Debounce FSM states: RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT.
  - RELEASED -> PRESS_WAIT when the scan candidate is a key; the stability counter is set to 1.
  - PRESS_WAIT: same key -> counter+1; counter reaching DEBOUNCE_SCANS -> HELD, and key_valid pulses with key_code updated that same cycle. Different key -> restart with the new key. NONE -> RELEASED.
  - HELD: candidate NONE -> RELEASE_WAIT. Other keys pressed while held are ignored, so a held key produces exactly one event.
  - RELEASE_WAIT: NONE for DEBOUNCE_SCANS consecutive scans -> RELEASED. Any key -> back to HELD.
- Entry FSM states: IDLE, CONVERT. Actions on key_valid while in IDLE:
  - Digit 0-9: if digit_count<4, entry_digits={entry_digits[11:0],code} and digit_count+1; otherwise ignored.
  - A (backspace): if digit_count>0, entry_digits>>4 and digit_count-1.
  - * (clear): entry_digits=0, digit_count=0.
  - #: if digit_count>0 -> CONVERT; if digit_count=0, ignored.
  - B, C, D: key_valid/key_code only; no entry action.
- CONVERT: acc starts at 0. Each of 4 cycles, acc=acc*10+nibble, taking nibbles from entry_digits[15:12] down to [3:0]. Leading zero nibbles are harmless. Maximum result is 9999, so there is no overflow in 16 bits.
- Latency: with # accepted at cycle T, CONVERT occupies T+1..T+4. At T+5, entry_value=acc, entry_done=1, entry_digits=0, digit_count=0, and the FSM returns to IDLE.
- key_valid arriving during CONVERT is dropped (unreachable for SCAN_DIV≥2, but required).
- entry_value holds its value until the next completed entry.

Decomposition:
- Shared package (display/keypad constants): key codes KEY_A..KEY_D, KEY_STAR=14, KEY_HASH=15, KEY_NONE sentinel, default SCAN_DIV.
- One sub-module: keypad_scanner. It holds the tick counter, row drive, synchronizer, scan-end candidate and debounce FSM, and outputs key_valid/key_code.
- The entry FSM and converter live in keypad_entry.

Test Plan (SCAN_DIV=8, DEBOUNCE_SCANS=2; keypad model connects col to the low row):
- Hold key '5' (row1,col1) for 6 scans, then release -> exactly one key_valid, key_code=5, entry_digits=16'h0005, digit_count=1.
- Press 1,2,3,4,7 then # -> the 7 is ignored; entry_done at key_valid(#)+5 cycles, entry_value=1234 (16'h04D2); entry_digits=0, digit_count=0.
- Press 9,0,A,5,# -> the backspace removes 0; entry_value=95.
- Key '8' contact bouncing for 1 scan only (then released) -> no key_valid. Press *, then # with an empty buffer -> buffer 0 and no entry_done.
- Hold '3' and '6' together -> key_code=3 (lowest index); releasing 3 while 6 is held -> no new event until a full release.
- Assert reset during CONVERT -> all outputs return to reset values immediately; row=4'b1110; no entry_done.
